// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer.
//   - RV32I funct3 width codes for loads and stores
//   - FSM state encoding used by lsu_ctrl
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic for a word-only RAM (purely combinational).
// Ports:
//   rd_word   in  32  word read from RAM (load source)
//   old_word  in  32  word read from RAM (read-modify-write base)
//   wdata     in  32  right-aligned store data
//   funct3    in  3   RV32I width code
//   off       in  2   byte offset within the word (addr[1:0])
//   ld_value  out 32  lane extracted from rd_word, sign/zero-extended
//   st_word   out 32  old_word with the addressed lane replaced by wdata
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] ld_value,
  output logic [31:0] st_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise unlisted funct3 codes would infer latches.
  always_comb begin
    byte_lane = 8'(rd_word >> {off, 3'b000});
    half_lane = off[1] ? rd_word[31:16] : rd_word[15:0];
    ld_value  = '0;
    case (funct3)
      F3_B:    ld_value = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    ld_value = {{16{half_lane[15]}}, half_lane};
      F3_W:    ld_value = rd_word;
      F3_BU:   ld_value = {24'h0, byte_lane};
      F3_HU:   ld_value = {16'h0, half_lane};
      default: ld_value = '0;
    endcase
  end

  always_comb begin
    st_word = old_word;
    case (funct3)
      F3_B: st_word[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (off[1]) st_word[31:16] = wdata[15:0];
        else        st_word[15:0]  = wdata[15:0];
      end
      F3_W:    st_word = wdata;
      default: st_word = old_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the core memory stage and a word-only RAM.
// Sub-word stores are done as read-modify-write; illegal requests never
// touch the RAM and complete with resp_err.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3       store flag, RV32I width code
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     load result (held until next accept), error flag
//   mem_wr_en, mem_addr      RAM write strobe, word-aligned byte address
//   mem_wr_data, mem_rd_data RAM write word, combinational RAM read word
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        req_err;
  logic [31:0] ld_value;
  logic [31:0] st_word;

  lsu_lane u_lane (
    .rd_word  (mem_rd_data),
    .old_word (mem_rd_data),
    .wdata    (wdata_q),
    .funct3   (funct3_q),
    .off      (off_q),
    .ld_value (ld_value),
    .st_word  (st_word)
  );

  // req_ready_q is only ever set in IDLE, so it doubles as the IDLE qualifier.
  assign accept = req_valid && req_ready_q;

  // Stores have no unsigned variants, so BU/HU codes are rejected for stores.
  always_comb begin
    req_err = 1'b0;
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])  req_err = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)                req_err = 1'b1;
    if (req_addr >= ADDR_LIMIT)                                      req_err = 1'b1;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
        req_funct3 == 3'b111)                                        req_err = 1'b1;
    if (req_we && req_funct3[2])                                     req_err = 1'b1;
  end

  // Outputs are registered: each *_d describes what the next state drives.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = 1'b0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = '0;
    funct3_d      = funct3_q;
    off_d         = off_q;
    wdata_d       = wdata_q;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        mem_addr_d  = '0;
        if (accept) begin
          req_ready_d  = 1'b0;
          funct3_d     = req_funct3;
          off_d        = req_addr[1:0];
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          if (req_err) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (!req_we) begin
              state_d = S_LOAD;
            end else if (req_funct3 == F3_W) begin
              state_d       = S_WRITE;
              mem_wr_en_d   = 1'b1;
              mem_wr_data_d = req_wdata;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_LOAD: begin
        resp_rdata_d = ld_value;
        resp_valid_d = 1'b1;
        mem_addr_d   = '0;
        state_d      = S_DONE;
      end
      S_RMW_RD: begin
        // Merge against the word read this cycle; the write happens next cycle.
        mem_wr_en_d   = 1'b1;
        mem_wr_data_d = st_word;
        state_d       = S_WRITE;
      end
      S_WRITE: begin
        resp_valid_d = 1'b1;
        mem_addr_d   = '0;
        state_d      = S_DONE;
      end
      S_DONE: begin
        req_ready_d = 1'b1;
        mem_addr_d  = '0;
        state_d     = S_IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        mem_addr_d  = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a behavioural 512-word RAM.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  logic [31:0] ram [512];
  int          wr_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_SIZE(512)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  assign mem_rd_data = ram[mem_addr[10:2]];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      ram[mem_addr[10:2]] <= mem_wr_data;
      wr_count     = wr_count + 1;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wr_data;
    end
  end

  // Issue one request, release req_valid after the accept edge, and report
  // latency (accept edge to resp_valid), response and first-cycle mem_addr.
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output logic [31:0] addr1);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    addr1 = mem_addr;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: resp_valid=%b required 1", name, resp_valid);
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic expect_resp(input string name, input int lat, input int exp_lat,
                             input logic [31:0] rdata, input logic [31:0] exp_rdata,
                             input logic err, input logic exp_err);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata got %h required %h", name, rdata, exp_rdata);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err got %b required %b", name, err, exp_err);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_wr_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got %b required 1000", {req_ready, resp_valid, resp_err, mem_wr_en});
    end
    checks++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_words got rdata=%h addr=%h wdata=%h required 0", resp_rdata, mem_addr, mem_wr_data);
    end
  endtask

  task automatic test_word;
    int lat, w0; logic [31:0] rd, a1; logic er;
    w0 = wr_count;
    do_req("sw", 1'b1, 3'b010, 32'h10, 32'h12345678, lat, rd, er, a1);
    expect_resp("sw", lat, 2, rd, 32'h0, er, 1'b0);
    checks++;
    if (wr_count - w0 != 1 || last_wr_addr !== 32'h10 || last_wr_data !== 32'h12345678) begin
      errors++;
      $display("FAIL sw_write got n=%0d addr=%h data=%h required 1/00000010/12345678",
               wr_count - w0, last_wr_addr, last_wr_data);
    end
    w0 = wr_count;
    do_req("lw", 1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, a1);
    expect_resp("lw", lat, 2, rd, 32'h12345678, er, 1'b0);
    checks++;
    if (a1 !== 32'h10 || wr_count != w0) begin
      errors++;
      $display("FAIL lw_mem got addr=%h writes=%0d required 00000010/0", a1, wr_count - w0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (resp_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rdata_hold got %h required 12345678", resp_rdata);
    end
  endtask

  task automatic test_byte;
    int lat; logic [31:0] rd, a1; logic er;
    do_req("sb", 1'b1, 3'b000, 32'h11, 32'h000000AB, lat, rd, er, a1);
    expect_resp("sb", lat, 3, rd, 32'h0, er, 1'b0);
    checks++;
    if (last_wr_addr !== 32'h10 || last_wr_data !== 32'h1234AB78) begin
      errors++;
      $display("FAIL sb_merge got addr=%h data=%h required 00000010/1234ab78", last_wr_addr, last_wr_data);
    end
    do_req("lb", 1'b0, 3'b000, 32'h11, 32'h0, lat, rd, er, a1);
    expect_resp("lb", lat, 2, rd, 32'hFFFFFFAB, er, 1'b0);
    do_req("lbu", 1'b0, 3'b100, 32'h11, 32'h0, lat, rd, er, a1);
    expect_resp("lbu", lat, 2, rd, 32'h000000AB, er, 1'b0);
  endtask

  task automatic test_half;
    int lat; logic [31:0] rd, a1; logic er;
    do_req("sh", 1'b1, 3'b001, 32'h12, 32'hFFFF8001, lat, rd, er, a1);
    expect_resp("sh", lat, 3, rd, 32'h0, er, 1'b0);
    checks++;
    if (last_wr_data !== 32'h8001AB78) begin
      errors++;
      $display("FAIL sh_merge got %h required 8001ab78", last_wr_data);
    end
    do_req("lh", 1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er, a1);
    expect_resp("lh", lat, 2, rd, 32'hFFFF8001, er, 1'b0);
    do_req("lhu", 1'b0, 3'b101, 32'h12, 32'h0, lat, rd, er, a1);
    expect_resp("lhu", lat, 2, rd, 32'h00008001, er, 1'b0);
  endtask

  task automatic test_errors;
    int lat, w0; logic [31:0] rd, a1; logic er;
    w0 = wr_count;
    do_req("err_lw_mis", 1'b0, 3'b010, 32'h13, 32'h0, lat, rd, er, a1);
    expect_resp("err_lw_mis", lat, 1, rd, 32'h0, er, 1'b1);
    do_req("err_sh_mis", 1'b1, 3'b001, 32'h21, 32'h1234, lat, rd, er, a1);
    expect_resp("err_sh_mis", lat, 1, rd, 32'h0, er, 1'b1);
    do_req("err_range", 1'b0, 3'b010, 32'h800, 32'h0, lat, rd, er, a1);
    expect_resp("err_range", lat, 1, rd, 32'h0, er, 1'b1);
    do_req("err_f3", 1'b0, 3'b011, 32'h0, 32'h0, lat, rd, er, a1);
    expect_resp("err_f3", lat, 1, rd, 32'h0, er, 1'b1);
    checks++;
    if (wr_count != w0) begin
      errors++;
      $display("FAIL err_no_write got %0d writes required 0", wr_count - w0);
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, w0; logic [31:0] rd, a1; logic er;
    do_req("rst_setup", 1'b1, 3'b010, 32'h30, 32'h11223344, lat, rd, er, a1);
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (mem_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_write got mem_wr_en=%b required 1", mem_wr_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0 || mem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_async got wr_en=%b ready=%b addr=%h wdata=%h required 0/1/0/0",
               mem_wr_en, req_ready, mem_addr, mem_wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wr_count != w0) begin
      errors++;
      $display("FAIL rst_no_write got %0d writes required 0", wr_count - w0);
    end
    do_req("rst_readback", 1'b0, 3'b010, 32'h30, 32'h0, lat, rd, er, a1);
    expect_resp("rst_readback", lat, 2, rd, 32'h11223344, er, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic        we_v [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3_v [3] = '{3'b010, 3'b010, 3'b000};
    logic [31:0] ad_v [3] = '{32'h10, 32'h44, 32'h45};
    logic [31:0] wd_v [3] = '{32'h0, 32'h55AA55AA, 32'h0000003C};
    int          lat_v[3] = '{2, 2, 3};
    logic [31:0] rd_v [3] = '{32'h8001AB78, 32'h0, 32'h0};
    int acc_cyc[3];
    int idx, nresp, ready_cnt, cyc, w0, lat; logic [31:0] rd, a1; logic er;
    idx = 0; nresp = 0; ready_cnt = 0; cyc = 0; w0 = wr_count;
    @(negedge clk);
    while (nresp < 3 && cyc < 40) begin
      if (resp_valid) begin
        checks++;
        if (cyc - acc_cyc[nresp] != lat_v[nresp] || resp_rdata !== rd_v[nresp] || resp_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_resp%0d got lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=0",
                   nresp, cyc - acc_cyc[nresp], resp_rdata, resp_err, lat_v[nresp], rd_v[nresp]);
        end
        nresp++;
        if (nresp == 3) req_valid = 1'b0;
      end
      if (req_ready) begin
        ready_cnt++;
        if (idx < 3) begin
          req_valid = 1'b1; req_we = we_v[idx]; req_funct3 = f3_v[idx];
          req_addr = ad_v[idx]; req_wdata = wd_v[idx];
          acc_cyc[idx] = cyc;
          idx++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    checks++;
    if (nresp != 3 || ready_cnt != 3) begin
      errors++;
      $display("FAIL b2b_count got resp=%0d ready=%0d required 3/3", nresp, ready_cnt);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_dup got resp_valid=%b required 0", resp_valid);
      end
    end
    checks++;
    if (wr_count - w0 != 2 || last_wr_data !== 32'h55AA3CAA) begin
      errors++;
      $display("FAIL b2b_writes got n=%0d data=%h required 2/55aa3caa", wr_count - w0, last_wr_data);
    end
    do_req("b2b_readback", 1'b0, 3'b010, 32'h44, 32'h0, lat, rd, er, a1);
    expect_resp("b2b_readback", lat, 2, rd, 32'h55AA3CAA, er, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
